mux_2x1_arb: RTL and testbench



---
 rtl/mux_pkg.sv | 19 +
 rtl/lane_fifo.sv | 83 ++++++++
 rtl/mux_2x1_arb.sv | 132 +++++++++++++
 tb/tb_mux_2x1_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and types for the 2:1 lane merger.
//            c_DATA_W_DEFAULT - default data bus width
//            lane_e           - lane index used for the selector and grant
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int c_DATA_W_DEFAULT = 8;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lane_fifo
// Purpose  : Synchronous DEPTH-entry FIFO for one input lane.
// Ports    : clk, reset   - clock, asynchronous active-high reset
//            data_i       - write data
//            push_i       - write request (dropped when full)
//            pop_i        - read request (ignored when empty)
//            head_o       - word at the read pointer
//            count_o      - number of stored words
//            full_o       - count equals DEPTH
//            overflow_o   - sticky: a write was dropped
// Revision : 1.0 - initial release
// ============================================================================
module lane_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    // Full is taken from the registered count only, so a push into a full
    // FIFO is dropped even when the same edge pops it.
    assign w_full = (count_q == CNT_W'(DEPTH));
    assign w_push = push_i & ~w_full;
    assign w_pop  = pop_i & (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are log2(DEPTH) bits wide and wrap on their own.
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            overflow_q <= overflow_q | (push_i & w_full);
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = w_full;
    assign overflow_o = overflow_q;

endmodule : lane_fifo
`default_nettype wire

// File: rtl/mux_2x1_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_arb
// Purpose  : Merges two valid-qualified lanes onto one registered output.
//            Each lane is buffered in a lane_fifo; an arbiter pops at most
//            one FIFO per cycle and tags the word with its source lane.
// Config   : ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//            ARB_ROUND_ROBIN_EN undefined -> fixed priority, lane 0 first
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            dataIn0/1, validIn0/1 - input lanes
//            full0/1               - lane FIFO full
//            overflow0/1           - sticky dropped-write flags
//            dataOut, validOut     - merged output word and strobe
//            selectorOut           - source lane of dataOut
// Revision : 1.0 - initial release
// ============================================================================
module mux_2x1_arb
    import mux_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic              validIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic              validIn1,
    output logic              full0,
    output logic              full1,
    output logic              overflow0,
    output logic              overflow1,
    output logic [DATA_W-1:0] dataOut,
    output logic              validOut,
    output logic              selectorOut
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  w_head0;
    logic [DATA_W-1:0]  w_head1;
    logic [c_CNT_W-1:0] w_count0;
    logic [c_CNT_W-1:0] w_count1;
    logic               w_ne0;
    logic               w_ne1;
    logic               w_pop0;
    logic               w_pop1;
    lane_e              w_lane;

    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    lane_e              sel_q;
`ifdef ARB_ROUND_ROBIN_EN
    lane_e              last_grant_q;
`endif

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .reset      (reset),
        .data_i     (dataIn0),
        .push_i     (validIn0),
        .pop_i      (w_pop0),
        .head_o     (w_head0),
        .count_o    (w_count0),
        .full_o     (full0),
        .overflow_o (overflow0)
    );

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .reset      (reset),
        .data_i     (dataIn1),
        .push_i     (validIn1),
        .pop_i      (w_pop1),
        .head_o     (w_head1),
        .count_o    (w_count1),
        .full_o     (full1),
        .overflow_o (overflow1)
    );

    assign w_ne0 = (w_count0 != '0);
    assign w_ne1 = (w_count1 != '0);

    // Arbitration looks only at the counts registered before the edge.
    always_comb begin
        w_pop0 = 1'b0;
        w_pop1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (w_ne0 && w_ne1) begin
            // Contention: serve the lane that did not win last time.
            if (last_grant_q == LANE1) w_pop0 = 1'b1;
            else                       w_pop1 = 1'b1;
        end else if (w_ne0) begin
            w_pop0 = 1'b1;
        end else if (w_ne1) begin
            w_pop1 = 1'b1;
        end
`else
        if (w_ne0)      w_pop0 = 1'b1;
        else if (w_ne1) w_pop1 = 1'b1;
`endif
        w_lane = w_pop1 ? LANE1 : LANE0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            sel_q        <= LANE0;
`ifdef ARB_ROUND_ROBIN_EN
            // Lane 0 wins the first contention after reset.
            last_grant_q <= LANE1;
`endif
        end else begin
            valid_q <= w_pop0 | w_pop1;
            // With no pop, data and selector hold their last values.
            if (w_pop0 | w_pop1) begin
                data_q       <= w_pop1 ? w_head1 : w_head0;
                sel_q        <= w_lane;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_q <= w_lane;
`endif
            end
        end
    end

    assign dataOut     = data_q;
    assign validOut    = valid_q;
    assign selectorOut = sel_q;

endmodule : mux_2x1_arb
`default_nettype wire

// File: tb/tb_mux_2x1_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2x1_arb
// Purpose  : Self-checking bench for mux_2x1_arb (DATA_W=8, DEPTH=4).
//            A queue-based reference model predicts every cycle's outputs,
//            which are pushed to a scoreboard and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2x1_arb;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dataIn0, dataIn1;
    logic          validIn0, validIn1;
    logic          full0, full1, overflow0, overflow1;
    logic [DW-1:0] dataOut;
    logic          validOut, selectorOut;

    mux_2x1_arb #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn0     (dataIn0),
        .validIn0    (validIn0),
        .dataIn1     (dataIn1),
        .validIn1    (validIn1),
        .full0       (full0),
        .full1       (full1),
        .overflow0   (overflow0),
        .overflow1   (overflow1),
        .dataOut     (dataOut),
        .validOut    (validOut),
        .selectorOut (selectorOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic          sel;
        logic          f0;
        logic          f1;
        logic          o0;
        logic          o1;
    } exp_t;

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          ev;
        logic [DW-1:0] ed;
        logic          es;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    exp_t          sb[$];
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    exp_t          m_out;
`ifdef ARB_ROUND_ROBIN_EN
    logic          m_lg;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        sb.delete();
        m_out = '0;
`ifdef ARB_ROUND_ROBIN_EN
        m_lg = 1'b1;
`endif
    endtask

    // Reference step, evaluated with the inputs sampled at the edge.
    task automatic model_step(input logic v0, input logic [DW-1:0] d0,
                              input logic v1, input logic [DW-1:0] d1);
        int  c0 = mq0.size();
        int  c1 = mq1.size();
        logic p0 = 1'b0;
        logic p1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (c0 > 0 && c1 > 0) begin
            if (m_lg) p0 = 1'b1; else p1 = 1'b1;
        end else if (c0 > 0) p0 = 1'b1;
        else if (c1 > 0)     p1 = 1'b1;
`else
        if (c0 > 0)      p0 = 1'b1;
        else if (c1 > 0) p1 = 1'b1;
`endif
        m_out.valid = p0 | p1;
        if (p0) begin
            m_out.data = mq0.pop_front();
            m_out.sel  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            m_lg = 1'b0;
`endif
        end
        if (p1) begin
            m_out.data = mq1.pop_front();
            m_out.sel  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            m_lg = 1'b1;
`endif
        end
        if (v0) begin
            if (c0 < DEPTH) mq0.push_back(d0);
            else            m_out.o0 = 1'b1;
        end
        if (v1) begin
            if (c1 < DEPTH) mq1.push_back(d1);
            else            m_out.o1 = 1'b1;
        end
        m_out.f0 = (mq0.size() == DEPTH);
        m_out.f1 = (mq1.size() == DEPTH);
        sb.push_back(m_out);
    endtask

    task automatic sb_compare();
        exp_t e;
        exp_t a;
        a = {validOut, dataOut, selectorOut, full0, full1, overflow0, overflow1};
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("cycle_outputs{v,d,s,f0,f1,o0,o1}", 32'(a), 32'(e));
        end
    endtask

    // One clock: drive, let the edge happen, predict, then compare 1 time unit later.
    task automatic cyc(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1);
        validIn0 = v0; dataIn0 = d0;
        validIn1 = v1; dataIn1 = d1;
        @(posedge clk);
        cyc_no++;
        model_step(v0, d0, v1, d1);
        #1;
        sb_compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'({validOut, dataOut, selectorOut, full0, full1, overflow0, overflow1}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    vec_t          vecs[6];
    logic [9:0]    cont_exp[8];
    logic          seen_full0;

    initial begin
        reset = 1'b1;
        validIn0 = 1'b0; validIn1 = 1'b0;
        dataIn0 = '0; dataIn1 = '0;
        model_reset();

        // Table: single words on each lane, latency and hold behaviour.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1};

`ifdef ARB_ROUND_ROBIN_EN
        cont_exp[0] = {1'b0, 1'b0, 8'h00};
        cont_exp[1] = {1'b1, 1'b0, 8'h10};
        cont_exp[2] = {1'b1, 1'b1, 8'h20};
        cont_exp[3] = {1'b1, 1'b0, 8'h11};
        cont_exp[4] = {1'b1, 1'b1, 8'h21};
        cont_exp[5] = {1'b1, 1'b0, 8'h12};
        cont_exp[6] = {1'b1, 1'b1, 8'h22};
        cont_exp[7] = {1'b0, 1'b1, 8'h22};
`else
        cont_exp[0] = {1'b0, 1'b0, 8'h00};
        cont_exp[1] = {1'b1, 1'b0, 8'h10};
        cont_exp[2] = {1'b1, 1'b0, 8'h11};
        cont_exp[3] = {1'b1, 1'b0, 8'h12};
        cont_exp[4] = {1'b1, 1'b1, 8'h20};
        cont_exp[5] = {1'b1, 1'b1, 8'h21};
        cont_exp[6] = {1'b1, 1'b1, 8'h22};
        cont_exp[7] = {1'b0, 1'b1, 8'h22};
`endif

        #2;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            check($sformatf("vec%0d{v,s,d}", i), 32'({validOut, selectorOut, dataOut}),
                  32'({vecs[i].ev, vecs[i].es, vecs[i].ed}));
        end

        // Contention: three words on each lane, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) cyc(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i));
            else       cyc(1'b0, '0, 1'b0, '0);
            check($sformatf("contention%0d{v,s,d}", i), 32'({validOut, selectorOut, dataOut}),
                  32'(cont_exp[i]));
        end

        // Overflow: eight words on both lanes back to back.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h40 + i));
        idle(12);
        check("overflow1_sticky", 32'(overflow1), 32'd1);

        // Wrap-around: ten bursts of three on lane 0 only.
        do_reset();
        seen_full0 = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int w = 0; w < 3; w++) begin
                cyc(1'b1, 8'(b * 3 + w + 8'h50), 1'b0, '0);
                seen_full0 |= full0;
            end
            idle(2);
            seen_full0 |= full0;
        end
        check("wrap_full0_never", 32'(seen_full0), 32'd0);

        // Reset mid-stream with words buffered and overflow set.
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b1, 8'(8'h70 + i));
        check("pre_reset_buffered", 32'(validOut), 32'd1);
        do_reset();
        idle(4);

        // Both lanes holding two words.
        cyc(1'b1, 8'h81, 1'b1, 8'h91);
        cyc(1'b1, 8'h82, 1'b1, 8'h92);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_2x1_arb
`default_nettype wire
